// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture block:
// FSM encoding and default widths.
package pwm_capture_pkg;

  localparam int A_DEF    = 8;
  localparam int SYNC_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_RISE = 2'd0;
  localparam state_t HIGH      = 2'd1;
  localparam state_t LOW       = 2'd2;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bus: the monitored line
// plus the published measurement.
interface pwm_capture_if #(
  parameter int A = 8
);

  logic         pwm_in;
  logic [A-1:0] period;
  logic [A-1:0] duty;
  logic         valid;
  logic         timeout;
  logic         stuck_high;
  logic         stuck_low;

  modport master (
    input  pwm_in,
    output period,
    output duty,
    output valid,
    output timeout,
    output stuck_high,
    output stuck_low
  );

  modport slave (
    output pwm_in,
    input  period,
    input  duty,
    input  valid,
    input  timeout,
    input  stuck_high,
    input  stuck_low
  );

endinterface

// File: rtl/pwm_capture_in_sync.sv
// Synchronizer for the async PWM line,
// with one-cycle rise/fall strobes.
module pwm_capture_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= w_s;
    end
  end

  assign o_rise = w_s & ~r_prev;
  assign o_fall = ~w_s & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM
// line; flags stuck lines on counter saturation.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int A           = A_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input logic         clk,
  input logic         reset,
  pwm_capture_if.master bus
);

  localparam logic [A-1:0] CNT_MAX = '1;
  localparam logic [A-1:0] CNT_ONE =
    {{(A-1){1'b0}}, 1'b1};

  logic         w_rise;
  logic         w_fall;
  logic         w_sat;

  state_t       r_state;
  logic [A-1:0] r_cnt;
  logic [A-1:0] r_hi_lat;
  logic [A-1:0] r_period;
  logic [A-1:0] r_duty;
  logic         r_valid;
  logic         r_timeout;
  logic         r_stuck_h;
  logic         r_stuck_l;

  pwm_capture_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.pwm_in),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  assign w_sat = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= WAIT_RISE;
      r_cnt     <= '0;
      r_hi_lat  <= '0;
      r_period  <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_stuck_h <= 1'b0;
      r_stuck_l <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        WAIT_RISE: begin
          if (w_rise) begin
            r_cnt   <= CNT_ONE;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          // a rise with no fall seen just restarts the count
          if (w_rise) begin
            r_cnt <= CNT_ONE;
          end else if (w_fall) begin
            r_hi_lat <= r_cnt;
            r_cnt    <= r_cnt + 1'b1;
            r_state  <= LOW;
          end else if (w_sat) begin
            r_timeout <= 1'b1;
            r_stuck_h <= 1'b1;
            r_stuck_l <= 1'b0;
            r_state   <= WAIT_RISE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOW: begin
          // edge wins over saturation: period of 2^A-1 is valid
          if (w_rise) begin
            r_period  <= r_cnt;
            r_duty    <= r_hi_lat;
            r_valid   <= 1'b1;
            r_stuck_h <= 1'b0;
            r_stuck_l <= 1'b0;
            r_cnt     <= CNT_ONE;
            r_state   <= HIGH;
          end else if (w_sat) begin
            r_timeout <= 1'b1;
            r_stuck_l <= 1'b1;
            r_stuck_h <= 1'b0;
            r_state   <= WAIT_RISE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_RISE;
        end
      endcase
    end
  end

  assign bus.period     = r_period;
  assign bus.duty       = r_duty;
  assign bus.valid      = r_valid;
  assign bus.timeout    = r_timeout;
  assign bus.stuck_high = r_stuck_h;
  assign bus.stuck_low  = r_stuck_l;

endmodule
